lsu_seq: RTL and testbench
==========================

// Module: lsu_seq
// PURPOSE
//  Sequential load/store unit: the registered, bus-handshaking successor to the combinational LSU.
//  Accepts one load/store per request from the core and checks natural alignment.
//  Runs a Wishbone-classic single cycle: byte-lane select, store-data replication,
//  load-data extraction with sign/zero extension. Ack wait is bounded by a timeout.
//  Sits between the core memory stage and the data bus; one transaction outstanding.
// PARAMETERS
//  DATA_W   32   bus/data width in bits, 32 or 64; NB = DATA_W/8 byte lanes, OB = log2(NB)
//  ADDR_W   32   address width
//  TIMEOUT  255  max cycles lsu_stb_o waits for ack/err before aborting (>=2)
// PORTS
//  clk_i           in   1        clock, rising edge
//  rst_i           in   1        reset, asynchronous, active-high
//  mem_req_i       in   1        core request valid; accepted when mem_ready_o=1
//  mem_ready_o     out  1        LSU idle, can accept a request
//  mem_we_i        in   1        1=store, 0=load
//  mem_type_i      in   2        11 word, 10 half, 01 byte, 00 dword (DATA_W=64 only)
//  mem_sign_i      in   1        load: 1=sign-extend, 0=zero-extend
//  mem_addr_i      in   ADDR_W   byte address
//  mem_dat_i       in   DATA_W   store data, right-aligned
//  mem_valid_o     out  1        one-cycle response pulse
//  mem_dat_o       out  DATA_W   load result, extended; held until next response
//  mem_err_o       out  1        response is an error (qualified by mem_valid_o)
//  mem_err_code_o  out  2        01 misaligned/illegal type, 10 bus err, 11 timeout
//  lsu_cyc_o       out  1        bus cycle active
//  lsu_stb_o       out  1        bus strobe
//  lsu_we_o        out  1        bus write enable
//  lsu_sel_o       out  NB       byte-lane selects
//  lsu_addr_o      out  ADDR_W   lane-aligned address (low OB bits 0)
//  lsu_dat_o       out  DATA_W   store data, replicated across lanes
//  lsu_dat_i       in   DATA_W   bus read data
//  lsu_ack_i       in   1        bus acknowledge
//  lsu_err_i       in   1        bus error
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0 except mem_ready_o=1. Clears timeout counter.
//   A bus cycle in progress is dropped immediately: cyc/stb go 0, no response is issued.
//  FSM IDLE->BUS->RESP->IDLE. Error path is IDLE->RESP. mem_ready_o = (state==IDLE), combinational.
//  IDLE: on mem_req_i, register we/type/sign/addr/data.
//   Size S = 1/2/4/8 bytes for byte/half/word/dword. off = addr[OB-1:0].
//   Misaligned (off mod S != 0), or type 00 when DATA_W=32: go to RESP with code 01. No bus cycle.
//   Otherwise go to BUS.
//  BUS: cyc=stb=1 starting the cycle after acceptance.
//   lsu_sel_o = ((1<<S)-1) << off. lsu_addr_o = {addr[ADDR_W-1:OB], OB'b0}.
//   lsu_we_o = we. lsu_dat_o = low S bytes of data replicated NB/S times.
//   All bus outputs are registered and stable while stb=1.
//   Timeout counter is 0 on entry and increments each BUS cycle that has no ack/err.
//   lsu_err_i=1: code 10, go to RESP. lsu_err_i wins if it arrives with lsu_ack_i.
//   lsu_ack_i=1: load data = (lsu_dat_i >> 8*off), low S bytes extended per mem_sign_i;
//    register it to mem_dat_o and go to RESP.
//   Counter==TIMEOUT-1 with no ack/err: code 11, go to RESP.
//   On leaving BUS, cyc/stb/we/sel go 0 in the same edge. An ack arriving in IDLE/RESP is ignored.
//  RESP: mem_valid_o=1 for exactly one cycle. mem_err_o=1 if a code is set.
//   Store: mem_dat_o is unchanged. Error: mem_dat_o=0. Then go to IDLE.
//  Latency: good access = 3 cycles + bus wait states (accept, stb, ack -> valid).
//   Misaligned access = valid on the 2nd cycle after acceptance.
//  mem_req_i is ignored while mem_ready_o=0; the core holds it until accepted.
// TESTING
//  DATA_W=32, SW 0xDEADBEEF @0x100, ack after 2 cycles
//   -> sel=1111, dat_o=DEADBEEF, one valid pulse, err=0
//  SB 0x5A @0x103 -> sel=1000, addr=0x100, dat_o=5A5A5A5A;
//   LB signed, bus data 0x80FF0000 -> mem_dat_o=FFFFFF80
//  LH @0x101 -> no cyc, valid on 2nd cycle, err=1, code=01;
//   LH unsigned @0x102, bus 0xBEEF1234 -> 0000BEEF
//  No ack, TIMEOUT=4 -> stb high exactly 4 cycles, then valid with code 11;
//   an ack and err in the same cycle -> code 10
//  DATA_W=64, SD @0x8 -> sel=FF; SW @0xC -> sel=F0;
//   type 00 with DATA_W=32 -> code 01
//  rst_i asserted mid-BUS -> cyc/stb 0 asynchronously, no valid; next request completes normally

Source files
------------

// File: rtl/lsu_seq.sv
// lsu_seq: registered load/store unit driving a Wishbone-classic single-cycle access with alignment check and ack timeout
module lsu_seq #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_req_i,
  output logic                   mem_ready_o,
  input  logic                   mem_we_i,
  input  logic [1:0]             mem_type_i,
  input  logic                   mem_sign_i,
  input  logic [ADDR_W-1:0]      mem_addr_i,
  input  logic [DATA_W-1:0]      mem_dat_i,
  output logic                   mem_valid_o,
  output logic [DATA_W-1:0]      mem_dat_o,
  output logic                   mem_err_o,
  output logic [1:0]             mem_err_code_o,
  output logic                   lsu_cyc_o,
  output logic                   lsu_stb_o,
  output logic                   lsu_we_o,
  output logic [DATA_W/8-1:0]    lsu_sel_o,
  output logic [ADDR_W-1:0]      lsu_addr_o,
  output logic [DATA_W-1:0]      lsu_dat_o,
  input  logic [DATA_W-1:0]      lsu_dat_i,
  input  logic                   lsu_ack_i,
  input  logic                   lsu_err_i
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_n;
  logic [3:0] size, size_q;
  logic [OB-1:0] off, off_q;
  logic bad, sign_q, timeout, done;
  logic [NB-1:0] sel_n;
  logic [DATA_W-1:0] rep, sh, mask, ld;
  logic [CW-1:0] cnt;
  logic [1:0] code;
  always_comb begin
    size = mem_type_i == 2'b11 ? 4'd4 : mem_type_i == 2'b10 ? 4'd2 : mem_type_i == 2'b01 ? 4'd1 : 4'd8;
    off = mem_addr_i[OB-1:0];
    bad = (mem_type_i == 2'b00 && DATA_W == 32) || ((off & OB'(size - 4'd1)) != '0);
    sel_n = NB'((9'd1 << size) - 9'd1) << off;
    rep = '0;
    for (int i = 0; i < NB; i++) rep[8*i +: 8] = mem_dat_i[8*(i % int'(size)) +: 8];
    // mask covers the low S bytes; its top bit picks out the sign of the loaded value
    sh = lsu_dat_i >> {off_q, 3'b000};
    mask = ~({DATA_W{1'b1}} << {size_q, 3'b000});
    ld = (sh & mask) | ((sign_q && |(sh & mask & ~(mask >> 1))) ? ~mask : '0);
    timeout = cnt == CW'(TIMEOUT - 1);
    done = lsu_err_i || lsu_ack_i || timeout;
    state_n = state == IDLE ? (mem_req_i ? (bad ? RESP : BUS) : IDLE) :
              state == BUS  ? (done ? RESP : BUS) : IDLE;
    mem_ready_o = state == IDLE;
    mem_valid_o = state == RESP;
    mem_err_o = mem_valid_o && code != 2'b00;
    mem_err_code_o = code;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      size_q <= '0;
      off_q <= '0;
      sign_q <= 1'b0;
      cnt <= '0;
      code <= 2'b00;
      mem_dat_o <= '0;
      lsu_cyc_o <= 1'b0;
      lsu_stb_o <= 1'b0;
      lsu_we_o <= 1'b0;
      lsu_sel_o <= '0;
      lsu_addr_o <= '0;
      lsu_dat_o <= '0;
    end else if (state == IDLE && mem_req_i) begin
      size_q <= size;
      off_q <= off;
      sign_q <= mem_sign_i;
      cnt <= '0;
      code <= bad ? 2'b01 : 2'b00;
      if (bad) mem_dat_o <= '0;
      else begin
        lsu_cyc_o <= 1'b1;
        lsu_stb_o <= 1'b1;
        lsu_we_o <= mem_we_i;
        lsu_sel_o <= sel_n;
        lsu_addr_o <= {mem_addr_i[ADDR_W-1:OB], {OB{1'b0}}};
        lsu_dat_o <= rep;
      end
    end else if (state == BUS) begin
      if (done) begin
        lsu_cyc_o <= 1'b0;
        lsu_stb_o <= 1'b0;
        lsu_we_o <= 1'b0;
        lsu_sel_o <= '0;
        code <= lsu_err_i ? 2'b10 : lsu_ack_i ? 2'b00 : 2'b11;
        if (lsu_err_i || !lsu_ack_i) mem_dat_o <= '0;
        else if (!lsu_we_o) mem_dat_o <= ld;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: scoreboard bench for lsu_seq, 32-bit instance with short timeout plus a 64-bit instance
module tb_lsu_seq;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req, ready, we, sign, valid, err, cyc, stb, bwe, ack, berr;
  logic [1:0] typ, code;
  logic [31:0] addr, wdat, rdat, baddr, bdat, brd;
  logic [3:0] sel;
  lsu_seq #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u32 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req), .mem_ready_o(ready), .mem_we_i(we),
    .mem_type_i(typ), .mem_sign_i(sign), .mem_addr_i(addr), .mem_dat_i(wdat),
    .mem_valid_o(valid), .mem_dat_o(rdat), .mem_err_o(err), .mem_err_code_o(code),
    .lsu_cyc_o(cyc), .lsu_stb_o(stb), .lsu_we_o(bwe), .lsu_sel_o(sel), .lsu_addr_o(baddr),
    .lsu_dat_o(bdat), .lsu_dat_i(brd), .lsu_ack_i(ack), .lsu_err_i(berr));
  logic req6, ready6, we6, sign6, valid6, err6, cyc6, stb6, bwe6, ack6, berr6;
  logic [1:0] typ6, code6;
  logic [31:0] addr6, baddr6;
  logic [63:0] wdat6, rdat6, bdat6, brd6;
  logic [7:0] sel6;
  lsu_seq #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) u64 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req6), .mem_ready_o(ready6), .mem_we_i(we6),
    .mem_type_i(typ6), .mem_sign_i(sign6), .mem_addr_i(addr6), .mem_dat_i(wdat6),
    .mem_valid_o(valid6), .mem_dat_o(rdat6), .mem_err_o(err6), .mem_err_code_o(code6),
    .lsu_cyc_o(cyc6), .lsu_stb_o(stb6), .lsu_we_o(bwe6), .lsu_sel_o(sel6), .lsu_addr_o(baddr6),
    .lsu_dat_o(bdat6), .lsu_dat_i(brd6), .lsu_ack_i(ack6), .lsu_err_i(berr6));
  typedef struct {logic e; logic [1:0] c; logic [31:0] d;} rsp_t;
  rsp_t q[$];
  int errors = 0, checks = 0;
  logic [31:0] last = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] sel_m(input logic [1:0] t, input logic [1:0] a);
    return t == 2'b01 ? 4'b0001 << a : t == 2'b10 ? 4'b0011 << a : 4'b1111;
  endfunction
  function automatic logic [31:0] rep_m(input logic [1:0] t, input logic [31:0] d);
    return t == 2'b01 ? {4{d[7:0]}} : t == 2'b10 ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic [31:0] ld_m(input logic [1:0] t, input logic s, input logic [1:0] a, input logic [31:0] b);
    logic [7:0] by;
    logic [15:0] hw;
    by = b[8*a +: 8];
    hw = a[1] ? b[31:16] : b[15:0];
    if (t == 2'b01) return s ? {{24{by[7]}}, by} : {24'h0, by};
    if (t == 2'b10) return s ? {{16{hw[15]}}, hw} : {16'h0, hw};
    return b;
  endfunction
  // mode: 0 ack after d wait states, 1 never answer, 2 ack+err together, 3 err only
  task automatic xfer(input logic w, input logic [1:0] t, input logic s, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] rd, input int dly, input int mode);
    rsp_t r;
    rsp_t got;
    logic bad;
    int lat, nstb;
    bit fin;
    bad = t == 2'b00 || (t == 2'b10 && a[0]) || (t == 2'b11 && a[1:0] != 2'b00);
    r.e = bad || mode != 0;
    r.c = bad ? 2'b01 : mode == 1 ? 2'b11 : mode != 0 ? 2'b10 : 2'b00;
    r.d = r.e ? 32'h0 : w ? last : ld_m(t, s, a[1:0], rd);
    last = r.d;
    lat = bad ? 1 : mode == 1 ? 1 + TO : 2 + dly;
    q.push_back(r);
    @(negedge clk);
    chk("ready", ready, 1);
    req = 1; we = w; typ = t; sign = s; addr = a; wdat = d; brd = rd;
    @(negedge clk);
    req = 0;
    nstb = 0;
    fin = 0;
    for (int n = 1; n <= 30 && !fin; n++) begin
      if (n > 1) @(negedge clk);
      ack = 0; berr = 0;
      if (valid) begin
        got = q.pop_front();
        chk("err", err, got.e);
        chk("code", code, got.c);
        chk("dat", rdat, got.d);
        chk("lat", n, lat);
        chk("nstb", nstb, bad ? 0 : mode == 1 ? TO : dly + 1);
        chk("cyc_off", cyc, 0);
        fin = 1;
      end else if (stb) begin
        nstb++;
        if (nstb == 1) begin
          chk("sel", sel, sel_m(t, a[1:0]));
          chk("addr", baddr, {a[31:2], 2'b00});
          chk("bwe", bwe, w);
          if (w) chk("bdat", bdat, rep_m(t, d));
        end
        if (nstb == dly + 1) begin
          ack = mode == 0 || mode == 2;
          berr = mode >= 2;
        end
      end
    end
    if (!fin) chk("resp_timeout", 0, 1);
    @(negedge clk);
    chk("pulse", valid, 0);
  endtask
  task automatic x64(input logic w, input logic [1:0] t, input logic s, input logic [31:0] a,
                     input logic [63:0] d, input logic [63:0] rd, input logic [7:0] xsel,
                     input logic [63:0] xbdat, input logic [63:0] xdat);
    bit fin;
    @(negedge clk);
    req6 = 1; we6 = w; typ6 = t; sign6 = s; addr6 = a; wdat6 = d; brd6 = rd;
    @(negedge clk);
    req6 = 0;
    fin = 0;
    for (int n = 1; n <= 20 && !fin; n++) begin
      if (n > 1) @(negedge clk);
      ack6 = 0;
      if (valid6) begin
        chk("d_err", err6, 0);
        chk("d_dat", rdat6, xdat);
        fin = 1;
      end else if (stb6) begin
        chk("d_sel", sel6, xsel);
        if (w) chk("d_bdat", bdat6, xbdat);
        ack6 = 1;
      end
    end
    if (!fin) chk("d_resp_timeout", 0, 1);
  endtask
  initial begin
    req = 0; we = 0; typ = 0; sign = 0; addr = 0; wdat = 0; brd = 0; ack = 0; berr = 0;
    req6 = 0; we6 = 0; typ6 = 0; sign6 = 0; addr6 = 0; wdat6 = 0; brd6 = 0; ack6 = 0; berr6 = 0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_sel", sel, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_code", code, 0);
    @(negedge clk);
    rst = 0;
    xfer(1, 2'b11, 0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0);
    xfer(1, 2'b01, 0, 32'h103, 32'h0000005A, 32'h0, 0, 0);
    xfer(0, 2'b01, 1, 32'h103, 32'h0, 32'h80FF0000, 1, 0);
    xfer(0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 0);
    xfer(0, 2'b10, 0, 32'h102, 32'h0, 32'hBEEF1234, 0, 0);
    xfer(1, 2'b10, 0, 32'h104, 32'h00001234, 32'h0, 0, 0);
    xfer(0, 2'b11, 0, 32'h200, 32'h0, 32'h0, 0, 1);
    xfer(0, 2'b11, 0, 32'h204, 32'h0, 32'h0, 1, 2);
    xfer(1, 2'b11, 0, 32'h208, 32'h1, 32'h0, 0, 3);
    xfer(0, 2'b00, 0, 32'h200, 32'h0, 32'h0, 0, 0);
    xfer(0, 2'b11, 0, 32'h106, 32'h0, 32'h0, 0, 0);
    xfer(0, 2'b10, 1, 32'h10, 32'h0, 32'h00008001, 0, 0);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] t;
      logic [31:0] a;
      t = 2'($urandom_range(1, 3));
      a = {22'h0, 8'($urandom), 2'b00};
      if (t == 2'b01) a[1:0] = 2'($urandom);
      if (t == 2'b10) a[1] = 1'($urandom);
      xfer(1'($urandom), t, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 2), 0);
    end
    @(negedge clk);
    req = 1; we = 0; typ = 2'b11; addr = 32'h300;
    @(negedge clk);
    req = 0;
    chk("rb_stb_on", stb, 1);
    #2 rst = 1;
    #1;
    chk("rb_stb", stb, 0);
    chk("rb_cyc", cyc, 0);
    chk("rb_ready", ready, 1);
    last = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rb_novalid", valid, 0);
    end
    xfer(0, 2'b11, 0, 32'h300, 32'h0, 32'hCAFEF00D, 1, 0);
    x64(1, 2'b00, 0, 32'h8, 64'h1122334455667788, 64'h0, 8'hFF, 64'h1122334455667788, 64'h0);
    x64(1, 2'b11, 0, 32'hC, 64'h00000000AABBCCDD, 64'h0, 8'hF0, 64'hAABBCCDDAABBCCDD, 64'h0);
    x64(0, 2'b11, 1, 32'hC, 64'h0, 64'h80000000_00000000, 8'hF0, 64'h0, 64'hFFFFFFFF80000000);
    x64(0, 2'b01, 0, 32'h15, 64'h0, 64'h0000_9A00_0000_0000, 8'h20, 64'h0, 64'h9A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
